// File: rtl/seq_timer_if.sv
// seq_timer_if: sequencer port bundle -- inst/inst_wen command in, out/error readback
interface seq_timer_if;
  logic [11:0] inst;
  logic inst_wen;
  logic [7:0] out;
  logic error;
  modport master(output inst, inst_wen, input out, error);
  modport slave(input inst, inst_wen, output out, error);
endinterface

// File: rtl/seq_timer.sv
// seq_timer: command-driven 8-bit prescaled down-counter; ports clock, reset (async high), bus (inst/inst_wen in, registered out/error)
module seq_timer (
  input logic clock,
  input logic reset,
  seq_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  localparam logic [3:0] LDC = 4'h1, LDP = 4'h2, STA = 4'h3, STP = 4'h4, RES = 4'h5;
  localparam logic [3:0] MOD = 4'h6, RDC = 4'h7, RDS = 4'h8, ACK = 4'h9;
  state_t st, st_n;
  logic [7:0] count, reload, presc, pcnt, count_n, reload_n, presc_n, pcnt_n, data, out_q;
  logic [3:0] cmd;
  logic mode, expired, sel, mode_n, exp_n, sel_n, bad, hold, run, tick, expire, err_q;
  always_comb begin
    cmd = (bus.inst_wen && st != ERR) ? bus.inst[11:8] : 4'h0;
    data = bus.inst[7:0];
    bad = cmd > ACK;
    hold = bad || cmd == STA || cmd == STP || cmd == RES;
    run = st == RUN && !hold;
    tick = run && pcnt == presc;
    expire = tick && count <= 8'd1;
    pcnt_n = cmd == STA ? 8'd0 : run ? (tick ? 8'd0 : pcnt + 8'd1) : pcnt;
    count_n = cmd == STA ? reload : !tick ? count : expire ? (mode ? reload : 8'd0) : count - 8'd1;
    reload_n = cmd == LDC ? data : reload;
    presc_n = cmd == LDP ? data : presc;
    mode_n = cmd == MOD ? data[0] : mode;
    sel_n = cmd == RDC ? 1'b0 : cmd == RDS ? 1'b1 : sel;
    exp_n = expire ? 1'b1 : cmd == ACK ? 1'b0 : expired;
    st_n = bad ? ERR : cmd == STA ? RUN : cmd == STP ? IDLE : (cmd == RES && st == IDLE) ? RUN :
           (expire && !mode) ? IDLE : st;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      count <= '0;
      reload <= '0;
      presc <= '0;
      pcnt <= '0;
      mode <= 1'b0;
      expired <= 1'b0;
      sel <= 1'b0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      st <= st_n;
      count <= count_n;
      reload <= reload_n;
      presc <= presc_n;
      pcnt <= pcnt_n;
      mode <= mode_n;
      expired <= exp_n;
      sel <= sel_n;
      out_q <= st_n == ERR ? 8'h00 : sel_n ? {6'b0, exp_n, st_n == RUN} : count_n;
      err_q <= st_n == ERR;
    end
  end
  assign bus.out = out_q;
  assign bus.error = err_q;
endmodule

// File: tb/tb_seq_timer.sv
// tb_seq_timer: random and directed command streams checked against a behavioural timer model
module tb_seq_timer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  seq_timer_if bus();
  seq_timer dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int n_vec = 0;
  int n_bad = 0;
  bit chk = 1'b0;
  int m_st, m_count, m_reload, m_presc, m_pcnt, m_mode, m_exp, m_sel;
  function automatic logic [7:0] m_out();
    return m_st == 2 ? 8'h00 : m_sel != 0 ? 8'(m_exp * 2 + (m_st == 1 ? 1 : 0)) : 8'(m_count);
  endfunction
  task automatic check(string name, logic [7:0] got_o, logic got_e, logic [7:0] want_o, logic want_e);
    n_vec++;
    if (got_o !== want_o || got_e !== want_e) begin
      n_bad++;
      $display("FAIL %s at %0t: out=%h error=%b, expected out=%h error=%b", name, $time, got_o, got_e, want_o, want_e);
    end
  endtask
  task automatic lit(string name, logic [7:0] want_o, logic want_e);
    check(name, bus.out, bus.error, want_o, want_e);
  endtask
  always @(negedge clock) if (chk) check("model", bus.out, bus.error, m_out(), m_st == 2);
  task automatic m_rst();
    m_st = 0; m_count = 0; m_reload = 0; m_presc = 0; m_pcnt = 0; m_mode = 0; m_exp = 0; m_sel = 0;
  endtask
  task automatic mstep(bit wen, int op, int d);
    int c;
    bit hold, tick, expire;
    c = (wen && m_st != 2) ? op : 0;
    if (c > 9) begin
      m_st = 2;
      return;
    end
    hold = (c == 3 || c == 4 || c == 5);
    tick = m_st == 1 && !hold && m_pcnt == m_presc;
    expire = tick && m_count <= 1;
    if (m_st == 1 && !hold) m_pcnt = tick ? 0 : (m_pcnt + 1) % 256;
    if (tick) begin
      if (expire) begin
        m_exp = 1;
        if (m_mode != 0) m_count = m_reload;
        else begin
          m_count = 0;
          m_st = 0;
        end
      end else m_count = m_count - 1;
    end
    case (c)
      1: m_reload = d;
      2: m_presc = d;
      3: begin m_count = m_reload; m_pcnt = 0; m_st = 1; end
      4: m_st = 0;
      5: if (m_st == 0) m_st = 1;
      6: m_mode = d % 2;
      7: m_sel = 0;
      8: m_sel = 1;
      9: if (!expire) m_exp = 0;
      default: ;
    endcase
  endtask
  task automatic cyc(int op, int d, bit wen = 1'b1);
    bus.inst = {4'(op), 8'(d)};
    bus.inst_wen = wen;
    @(posedge clock);
    mstep(wen, op, d);
    #1 bus.inst_wen = 1'b0;
  endtask
  task automatic apulse();
    #1 reset = 1'b1;
    m_rst();
    #1 lit("async_reset", 8'h00, 1'b0);
    reset = 1'b0;
  endtask
  int r, op, d;
  bit w;
  initial begin
    bus.inst = '0;
    bus.inst_wen = 1'b0;
    m_rst();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk = 1'b1;
    lit("reset_state", 8'h00, 1'b0);
    cyc(8, 0); lit("rds_after_reset", 8'h00, 1'b0);
    cyc(1, 3); cyc(2, 0); cyc(7, 0);
    cyc(3, 0); lit("oneshot_e0", 8'h03, 1'b0);
    cyc(0, 0); lit("oneshot_e1", 8'h02, 1'b0);
    cyc(0, 0); lit("oneshot_e2", 8'h01, 1'b0);
    cyc(0, 0); lit("oneshot_e3", 8'h00, 1'b0);
    cyc(8, 0); lit("oneshot_status", 8'h02, 1'b0);
    apulse();
    cyc(6, 1); cyc(1, 2); cyc(2, 1); cyc(7, 0);
    cyc(3, 0); lit("auto_e0", 8'h02, 1'b0);
    cyc(0, 0); lit("auto_e1", 8'h02, 1'b0);
    cyc(0, 0); lit("auto_e2", 8'h01, 1'b0);
    cyc(0, 0); lit("auto_e3", 8'h01, 1'b0);
    cyc(0, 0); lit("auto_e4", 8'h02, 1'b0);
    cyc(0, 0); lit("auto_e5", 8'h02, 1'b0);
    cyc(0, 0); lit("auto_e6", 8'h01, 1'b0);
    cyc(8, 0); lit("auto_status", 8'h03, 1'b0);
    cyc(9, 0); lit("ack_vs_tick", 8'h03, 1'b0);
    cyc(9, 0); lit("ack_clears", 8'h01, 1'b0);
    cyc(0, 0); lit("auto_e10", 8'h01, 1'b0);
    cyc(0, 0); lit("auto_e11", 8'h01, 1'b0);
    cyc(0, 0); lit("auto_reexpire", 8'h03, 1'b0);
    apulse();
    cyc(1, 6); cyc(2, 0);
    cyc(3, 0); lit("stp_sta", 8'h06, 1'b0);
    cyc(0, 0); lit("stp_run", 8'h05, 1'b0);
    cyc(4, 0); lit("stp_edge", 8'h05, 1'b0);
    repeat (9) begin cyc(0, 0); lit("stp_hold", 8'h05, 1'b0); end
    cyc(5, 0); lit("res_edge", 8'h05, 1'b0);
    cyc(0, 0); lit("res_tick", 8'h04, 1'b0);
    cyc(4'hB, 0); lit("illegal", 8'h00, 1'b1);
    cyc(3, 0); lit("err_sta_ignored", 8'h00, 1'b1);
    cyc(8, 0); lit("err_rds_ignored", 8'h00, 1'b1);
    apulse();
    cyc(1, 9);
    cyc(3, 0); lit("mid_e0", 8'h09, 1'b0);
    cyc(0, 0); cyc(0, 0); lit("mid_e2", 8'h07, 1'b0);
    apulse();
    cyc(1, 1);
    cyc(3, 0); lit("post_rst_sta", 8'h01, 1'b0);
    cyc(0, 0); lit("post_rst_tick", 8'h00, 1'b0);
    cyc(8, 0); lit("post_rst_status", 8'h02, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) op = $urandom_range(10, 15);
      else if (r < 40) op = 0;
      else op = $urandom_range(1, 9);
      d = op == 2 ? $urandom_range(0, 3) : op == 1 ? $urandom_range(0, 6) : $urandom_range(0, 255);
      w = $urandom_range(0, 3) != 0;
      cyc(op, d, w);
      if (m_st == 2 ? $urandom_range(0, 9) == 0 : $urandom_range(0, 299) == 0) apulse();
    end
    @(negedge clock);
    #1 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
